// File: rtl/fmdll_lock_ctrl.sv
// Lock-acquisition sequencer for the FMC multiplier: loads an M/N ratio, lets the loop settle,
// then compares DIV_N against DIV_M edge counts over fixed windows to report lock or failure.
module fmdll_lock_ctrl #(
  parameter int unsigned LOAD_CYC   = 4,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned WIN_LEN    = 16,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_WIN   = 3,
  parameter int unsigned MAX_FAIL   = 8,
  parameter int unsigned WDOG_CYC   = 1024
) (
  input  logic       clk_ext,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_m,
  input  logic [3:0] cfg_n,
  input  logic       div_m,
  input  logic       div_n,
  output logic       fmc_rst_n,
  output logic [1:0] m,
  output logic [3:0] n,
  output logic [1:0] m_counter,
  output logic [3:0] n_counter,
  output logic       locked,
  output logic [1:0] lock_err
);

  localparam int unsigned SeqMax = (SETTLE_CYC > LOAD_CYC) ? SETTLE_CYC : LOAD_CYC;
  localparam int SeqW  = $clog2(SeqMax + 1);
  localparam int WdogW = $clog2(WDOG_CYC + 1);
  localparam int PassW = $clog2(LOCK_WIN + 1);
  localparam int FailW = $clog2(MAX_FAIL + 1);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrCfg  = 2'b01;
  localparam logic [1:0] ErrLock = 2'b10;
  localparam logic [1:0] ErrWdog = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StMeasure,
    StLocked,
    StError
  } state_e;

  state_e             state_q;
  logic [SeqW-1:0]    seq_q;
  logic [WdogW-1:0]   wdog_q;
  logic [7:0]         win_m_q;
  logic [7:0]         n_cnt_q;
  logic [PassW-1:0]   pass_q;
  logic [FailW-1:0]   fail_q;

  logic dm_q, dn_s1_q, dn_s2_q, dn_s3_q, n_edge_q;
  logic m_edge;

  logic              accept;
  logic [7:0]        n_next;
  logic              win_end;
  logic signed [8:0] diff;
  logic [8:0]        diff_abs;
  logic              win_pass;
  logic              wdog_expire;

  // div_n crosses from clk_out: 2-FF synchronizer followed by a registered edge pulse.
  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      dm_q     <= 1'b0;
      dn_s1_q  <= 1'b0;
      dn_s2_q  <= 1'b0;
      dn_s3_q  <= 1'b0;
      n_edge_q <= 1'b0;
    end else begin
      dm_q     <= div_m;
      dn_s1_q  <= div_n;
      dn_s2_q  <= dn_s1_q;
      dn_s3_q  <= dn_s2_q;
      n_edge_q <= dn_s2_q & ~dn_s3_q;
    end
  end

  assign m_edge    = div_m & ~dm_q;
  assign cfg_ready = (state_q == StIdle) || (state_q == StLocked) || (state_q == StError);
  assign accept    = cfg_valid & cfg_ready;
  assign m_counter = 2'd0;
  assign n_counter = 4'd0;

  always_comb begin
    n_next = n_cnt_q;
    if (n_edge_q && (n_cnt_q != 8'hff)) begin
      n_next = n_cnt_q + 8'd1;
    end
    // The closing cycle's div_n edge belongs to the window being judged.
    win_end     = m_edge && (win_m_q == 8'(WIN_LEN - 1));
    diff        = $signed({1'b0, n_next}) - $signed(9'(WIN_LEN));
    diff_abs    = diff[8] ? 9'(-diff) : 9'(diff);
    win_pass    = (diff_abs <= 9'(TOL));
    wdog_expire = !m_edge && (wdog_q == WdogW'(WDOG_CYC - 1));
  end

  always_ff @(posedge clk_ext or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      fmc_rst_n <= 1'b0;
      m         <= 2'd0;
      n         <= 4'd0;
      locked    <= 1'b0;
      lock_err  <= ErrNone;
      seq_q     <= '0;
      wdog_q    <= '0;
      win_m_q   <= '0;
      n_cnt_q   <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
    end else if (accept) begin
      locked    <= 1'b0;
      fmc_rst_n <= 1'b0;
      seq_q     <= '0;
      wdog_q    <= '0;
      win_m_q   <= '0;
      n_cnt_q   <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      if ((cfg_m == 2'd0) || (cfg_n == 4'd0)) begin
        state_q  <= StError;
        lock_err <= ErrCfg;
      end else begin
        m        <= cfg_m;
        n        <= cfg_n;
        lock_err <= ErrNone;
        state_q  <= StLoad;
      end
    end else begin
      unique case (state_q)
        StIdle, StError: ;
        StLoad: begin
          if (seq_q == SeqW'(LOAD_CYC - 1)) begin
            seq_q     <= '0;
            fmc_rst_n <= 1'b1;
            state_q   <= StSettle;
          end else begin
            seq_q <= seq_q + SeqW'(1);
          end
        end
        StSettle: begin
          if (seq_q == SeqW'(SETTLE_CYC - 1)) begin
            seq_q   <= '0;
            wdog_q  <= '0;
            win_m_q <= '0;
            n_cnt_q <= '0;
            state_q <= StMeasure;
          end else begin
            seq_q <= seq_q + SeqW'(1);
          end
        end
        StMeasure, StLocked: begin
          if (wdog_expire) begin
            state_q   <= StError;
            lock_err  <= ErrWdog;
            locked    <= 1'b0;
            fmc_rst_n <= 1'b0;
            wdog_q    <= '0;
            win_m_q   <= '0;
            n_cnt_q   <= '0;
          end else begin
            wdog_q <= m_edge ? '0 : wdog_q + WdogW'(1);
            if (win_end) begin
              win_m_q <= '0;
              n_cnt_q <= '0;
              if (state_q == StMeasure) begin
                if (win_pass) begin
                  if (pass_q == PassW'(LOCK_WIN - 1)) begin
                    pass_q  <= '0;
                    locked  <= 1'b1;
                    state_q <= StLocked;
                  end else begin
                    pass_q <= pass_q + PassW'(1);
                  end
                end else begin
                  pass_q <= '0;
                  if (fail_q == FailW'(MAX_FAIL - 1)) begin
                    fail_q    <= fail_q + FailW'(1);
                    state_q   <= StError;
                    lock_err  <= ErrLock;
                    fmc_rst_n <= 1'b0;
                  end else begin
                    fail_q <= fail_q + FailW'(1);
                  end
                end
              end else if (!win_pass) begin
                // A single bad window while locked restarts acquisition, counting as one fail.
                locked  <= 1'b0;
                pass_q  <= '0;
                fail_q  <= FailW'(1);
                state_q <= StMeasure;
              end
            end else begin
              win_m_q <= win_m_q + {7'd0, m_edge};
              n_cnt_q <= n_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
